// File: rtl/fft_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer_if
// Purpose  : Bundles the sample stream, the FFT core frame buses and the
//            result stream of fft_frame_sequencer into one interface.
// Ports    : (interface signals)
//   abort                  synchronous frame flush request
//   in_valid/in_ready      sample handshake, in_re/in_im sample data
//   frame_ifft             transform direction, taken with sample 0
//   core_start/core_ifft   core start pulse and latched direction
//   core_in_re/core_in_im  frame buffer towards the core (natural order)
//   core_out_re/_im        results coming back from the core
//   out_valid/out_ready    result handshake, out_re/out_im/out_index/out_last
//   busy, frame_done       status
// Modports : slave  - sequencer side
//            master - environment side (sample source, core, result sink)
// Revision : 1.0 - initial release
// ============================================================================
interface fft_frame_sequencer_if #(
  parameter int D_WIDTH     = 64,
  parameter int LOG_2_WIDTH = 6
);
  logic                         abort;
  logic                         in_valid;
  logic                         in_ready;
  logic [15:0]                  in_re;
  logic [15:0]                  in_im;
  logic                         frame_ifft;
  logic                         core_start;
  logic                         core_ifft;
  logic [D_WIDTH-1:0][15:0]     core_in_re;
  logic [D_WIDTH-1:0][15:0]     core_in_im;
  logic [D_WIDTH-1:0][15:0]     core_out_re;
  logic [D_WIDTH-1:0][15:0]     core_out_im;
  logic                         out_valid;
  logic                         out_ready;
  logic [15:0]                  out_re;
  logic [15:0]                  out_im;
  logic [LOG_2_WIDTH-1:0]       out_index;
  logic                         out_last;
  logic                         busy;
  logic                         frame_done;

  modport slave (
    input  abort, in_valid, in_re, in_im, frame_ifft,
           core_out_re, core_out_im, out_ready,
    output in_ready, core_start, core_ifft, core_in_re, core_in_im,
           out_valid, out_re, out_im, out_index, out_last, busy, frame_done
  );

  modport master (
    output abort, in_valid, in_re, in_im, frame_ifft,
           core_out_re, core_out_im, out_ready,
    input  in_ready, core_start, core_ifft, core_in_re, core_in_im,
           out_valid, out_re, out_im, out_index, out_last, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fft_frame_sequencer
// Purpose  : Frame controller for the 64-point in-place FFT/IFFT core.
//            Gathers D_WIDTH samples into a parallel buffer, pulses the core
//            start, waits the fixed compute latency, then streams the results
//            out in index order under valid/ready flow control.
// Ports    :
//   clk  - system clock, rising edge
//   rst  - synchronous reset, active low
//   bus  - fft_frame_sequencer_if.slave (sample, core and result signals)
// Revision : 1.0 - initial release
// ============================================================================
module fft_frame_sequencer #(
  parameter int D_WIDTH        = 64,
  parameter int LOG_2_WIDTH    = 6,
  parameter int COMPUTE_CYCLES = 192
) (
  input  wire logic            clk,
  input  wire logic            rst,
  fft_frame_sequencer_if.slave bus
);

  // Compute counter only has to reach COMPUTE_CYCLES-1.
  localparam int CMP_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  localparam logic [CMP_W-1:0]       C_CMP_LAST = CMP_W'(COMPUTE_CYCLES - 1);
  localparam logic [LOG_2_WIDTH-1:0] C_IDX_LAST = LOG_2_WIDTH'(D_WIDTH - 1);

  localparam logic [1:0] S_LOAD    = 2'd0;
  localparam logic [1:0] S_START   = 2'd1;
  localparam logic [1:0] S_COMPUTE = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]               r_state;
  logic [LOG_2_WIDTH-1:0]   r_ld_cnt;
  logic [CMP_W-1:0]         r_cmp_cnt;
  logic [LOG_2_WIDTH-1:0]   r_out_index;
  logic [D_WIDTH-1:0][15:0] r_core_in_re;
  logic [D_WIDTH-1:0][15:0] r_core_in_im;
  logic                     r_core_ifft;
  logic                     r_frame_done;

  logic w_in_accept;
  logic w_out_accept;
  logic w_out_last;

  assign w_in_accept  = (r_state == S_LOAD)  && bus.in_valid;
  assign w_out_accept = (r_state == S_DRAIN) && bus.out_ready;
  assign w_out_last   = (r_state == S_DRAIN) && (r_out_index == C_IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_LOAD;
      r_ld_cnt     <= '0;
      r_cmp_cnt    <= '0;
      r_out_index  <= '0;
      r_core_in_re <= '0;
      r_core_in_im <= '0;
      r_core_ifft  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (bus.abort) begin
        // Flush: the frame buffer and direction are deliberately left alone.
        r_state     <= S_LOAD;
        r_ld_cnt    <= '0;
        r_cmp_cnt   <= '0;
        r_out_index <= '0;
      end else begin
        case (r_state)
          S_LOAD: begin
            if (w_in_accept) begin
              r_core_in_re[r_ld_cnt] <= bus.in_re;
              r_core_in_im[r_ld_cnt] <= bus.in_im;
              if (r_ld_cnt == '0) begin
                r_core_ifft <= bus.frame_ifft;
              end
              if (r_ld_cnt == C_IDX_LAST) begin
                r_ld_cnt <= '0;
                r_state  <= S_START;
              end else begin
                r_ld_cnt <= r_ld_cnt + 1'b1;
              end
            end
          end
          S_START: begin
            r_cmp_cnt <= '0;
            r_state   <= S_COMPUTE;
          end
          S_COMPUTE: begin
            if (r_cmp_cnt == C_CMP_LAST) begin
              r_cmp_cnt   <= '0;
              r_out_index <= '0;
              r_state     <= S_DRAIN;
            end else begin
              r_cmp_cnt <= r_cmp_cnt + 1'b1;
            end
          end
          S_DRAIN: begin
            if (w_out_accept) begin
              if (w_out_last) begin
                r_out_index  <= '0;
                r_frame_done <= 1'b1;
                r_state      <= S_LOAD;
              end else begin
                r_out_index <= r_out_index + 1'b1;
              end
            end
          end
          default: begin
            r_state <= S_LOAD;
          end
        endcase
      end
    end
  end

  // Handshake/status outputs decode straight from state so the start pulse
  // still fires in a START cycle that coincides with abort.
  assign bus.in_ready    = (r_state == S_LOAD);
  assign bus.core_start  = (r_state == S_START);
  assign bus.core_ifft   = r_core_ifft;
  assign bus.core_in_re  = r_core_in_re;
  assign bus.core_in_im  = r_core_in_im;
  assign bus.out_valid   = (r_state == S_DRAIN);
  assign bus.out_re      = bus.core_out_re[r_out_index];
  assign bus.out_im      = bus.core_out_im[r_out_index];
  assign bus.out_index   = r_out_index;
  assign bus.out_last    = w_out_last;
  assign bus.busy        = (r_state != S_LOAD) || (r_ld_cnt != '0);
  assign bus.frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_frame_sequencer
// Purpose  : Self-checking bench for fft_frame_sequencer with a stubbed core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_frame_sequencer;
  localparam int D = 64;
  localparam int L = 6;
  localparam int C = 192;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] exp_re [D];
  logic [15:0] exp_im [D];
  logic [15:0] stub_re [D];
  logic [15:0] stub_im [D];

  fft_frame_sequencer_if #(.D_WIDTH(D), .LOG_2_WIDTH(L)) bus ();

  fft_frame_sequencer #(.D_WIDTH(D), .LOG_2_WIDTH(L), .COMPUTE_CYCLES(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stub core: fixed result table, ramp 1000+i or random.
  task automatic set_stub(input bit ramp);
    for (int i = 0; i < D; i++) begin
      stub_re[i] = ramp ? 16'(1000 + i) : 16'($urandom);
      stub_im[i] = 16'($urandom);
      bus.core_out_re[i] = stub_re[i];
      bus.core_out_im[i] = stub_im[i];
    end
  endtask

  // Back-to-back load of one frame; frame_ifft is inverted after sample 0.
  task automatic load_frame(input bit ramp, input bit ifft);
    for (int i = 0; i < D; i++) begin
      exp_re[i] = ramp ? 16'(i)  : 16'($urandom);
      exp_im[i] = ramp ? 16'(-i) : 16'($urandom);
      bus.in_valid   = 1'b1;
      bus.in_re      = exp_re[i];
      bus.in_im      = exp_im[i];
      bus.frame_ifft = (i == 0) ? ifft : ~ifft;
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
  endtask

  function automatic int frame_bad();
    int bad = 0;
    for (int i = 0; i < D; i++)
      if (bus.core_in_re[i] !== exp_re[i] || bus.core_in_im[i] !== exp_im[i]) bad++;
    return bad;
  endfunction

  function automatic int zero_bad();
    int bad = 0;
    for (int i = 0; i < D; i++)
      if (bus.core_in_re[i] !== 16'h0 || bus.core_in_im[i] !== 16'h0) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_re = '0; bus.in_im = '0;
    bus.frame_ifft = 1'b0; bus.out_ready = 1'b0;
    rst = 1'b0;
    tick(); tick();
    checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", bus.core_start); end
    checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0)   begin errors++; $display("FAIL reset_out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.out_index !== 6'd0)  begin errors++; $display("FAIL reset_out_index: got %0d want 0", bus.out_index); end
    checks++; if (bus.core_ifft !== 1'b0)  begin errors++; $display("FAIL reset_core_ifft: got %b want 0", bus.core_ifft); end
    checks++; if (zero_bad() != 0)         begin errors++; $display("FAIL reset_core_in: got %0d nonzero words want 0", zero_bad()); end
    rst = 1'b1;
    tick();
    checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_ramp_latency();
    int n; int starts = 0; int ready_hi = 0; int bad = 0; int lasts = 0; int dones = 0;
    set_stub(1'b1);
    load_frame(1'b1, 1'b0);
    checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL ramp_start: got %b want 1", bus.core_start); end
    checks++; if (bus.in_ready !== 1'b0)   begin errors++; $display("FAIL ramp_ready_start: got %b want 0", bus.in_ready); end
    checks++; if (frame_bad() != 0)        begin errors++; $display("FAIL ramp_core_in: got %0d bad words want 0", frame_bad()); end
    checks++; if (bus.core_ifft !== 1'b0)  begin errors++; $display("FAIL ramp_ifft: got %b want 0", bus.core_ifft); end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      tick(); n++;
      if (bus.core_start === 1'b1) starts++;
      if (bus.in_ready !== 1'b0) ready_hi++;
    end
    checks++; if (n != C + 1)   begin errors++; $display("FAIL ramp_latency: got %0d want %0d", n, C + 1); end
    checks++; if (starts != 0)  begin errors++; $display("FAIL ramp_start_width: got %0d extra start cycles want 0", starts); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (bus.out_valid !== 1'b1 || bus.out_index !== L'(k) ||
          bus.out_re !== 16'(1000 + k) || bus.out_im !== stub_im[k]) bad++;
      if (bus.out_last === 1'b1) begin lasts++; if (k != D - 1) bad++; end
      if (bus.frame_done === 1'b1) dones++;
      if (bus.in_ready !== 1'b0) ready_hi++;
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (bad != 0)      begin errors++; $display("FAIL ramp_drain: got %0d bad beats want 0", bad); end
    checks++; if (lasts != 1)    begin errors++; $display("FAIL ramp_last_count: got %0d want 1", lasts); end
    checks++; if (ready_hi != 0) begin errors++; $display("FAIL ramp_ready_low: got %0d high cycles want 0", ready_hi); end
    checks++; if (dones != 0)    begin errors++; $display("FAIL ramp_early_done: got %0d want 0", dones); end
    checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL ramp_done: got %b want 1", bus.frame_done); end
    checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL ramp_ready_back: got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL ramp_busy_end: got %b want 0", bus.busy); end
    tick();
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL ramp_done_pulse: got %b want 0", bus.frame_done); end
  endtask

  task automatic test_backpressure();
    int n; int acc = 0; int cyc = 0; int bad = 0; int dones = 0;
    logic [3:0] pat = 4'b1001;
    set_stub(1'b0);
    load_frame(1'b0, 1'($urandom));
    wait_valid(n);
    checks++; if (n != C + 1) begin errors++; $display("FAIL bp_latency: got %0d want %0d", n, C + 1); end
    while (acc < D && cyc < 400) begin
      bus.out_ready = pat[cyc % 4];
      if (bus.out_valid !== 1'b1 || bus.out_index !== L'(acc) ||
          bus.out_re !== stub_re[acc] || bus.out_im !== stub_im[acc]) bad++;
      if (bus.out_ready) acc++;
      tick(); cyc++;
      if (bus.frame_done === 1'b1) dones++;
    end
    bus.out_ready = 1'b0;
    checks++; if (acc != D)  begin errors++; $display("FAIL bp_accepts: got %0d want %0d", acc, D); end
    checks++; if (bad != 0)  begin errors++; $display("FAIL bp_stream: got %0d bad beats want 0", bad); end
    checks++; if (dones != 1 || bus.frame_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %0d pulses want 1 on final beat", dones); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_extra_valid: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_gaps_direction();
    int acc = 0; int cyc = 0; int bad_busy = 0; int bad_ifft = 0; int bad_start = 0; int n; int bad = 0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL gaps_idle_busy: got %b want 0", bus.busy); end
    while (acc < D && cyc < 3 * D + 10) begin
      bus.in_valid = (cyc % 3 == 0);
      bus.in_re = 16'($urandom); bus.in_im = 16'($urandom);
      bus.frame_ifft = (acc == 0) ? 1'b1 : 1'b0;
      if (bus.in_valid) begin exp_re[acc] = bus.in_re; exp_im[acc] = bus.in_im; end
      tick(); cyc++;
      if (bus.in_valid) acc++;
      if (acc > 0 && acc < D) begin
        if (bus.busy !== 1'b1) bad_busy++;
        if (bus.core_ifft !== 1'b1) bad_ifft++;
        if (bus.core_start !== 1'b0) bad_start++;
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (bad_busy != 0)  begin errors++; $display("FAIL gaps_busy: got %0d low cycles want 0", bad_busy); end
    checks++; if (bad_start != 0) begin errors++; $display("FAIL gaps_early_start: got %0d want 0", bad_start); end
    checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL gaps_start: got %b want 1", bus.core_start); end
    checks++; if (frame_bad() != 0) begin errors++; $display("FAIL gaps_core_in: got %0d bad words want 0", frame_bad()); end
    set_stub(1'b0);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 400) begin
      tick(); n++;
      if (bus.core_ifft !== 1'b1) bad_ifft++;
    end
    checks++; if (n != C + 1) begin errors++; $display("FAIL gaps_latency: got %0d want %0d", n, C + 1); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < D; k++) begin
      if (bus.out_index !== L'(k) || bus.out_re !== stub_re[k] || bus.out_im !== stub_im[k]) bad++;
      if (bus.core_ifft !== 1'b1) bad_ifft++;
      tick();
    end
    bus.out_ready = 1'b0;
    checks++; if (bad != 0)      begin errors++; $display("FAIL gaps_drain: got %0d bad beats want 0", bad); end
    checks++; if (bad_ifft != 0) begin errors++; $display("FAIL gaps_ifft: got %0d wrong cycles want 0", bad_ifft); end
    checks++; if (bus.frame_done !== 1'b1) begin errors++; $display("FAIL gaps_done: got %b want 1", bus.frame_done); end
  endtask

  task automatic test_abort_start();
    load_frame(1'b0, 1'b1);
    bus.abort = 1'b1;
    checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL abort_start_pulse: got %b want 1", bus.core_start); end
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL abort_start_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL abort_start_busy: got %b want 0", bus.busy); end
    checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL abort_start_low: got %b want 0", bus.core_start); end
    checks++; if (frame_bad() != 0)        begin errors++; $display("FAIL abort_start_keep: got %0d bad words want 0", frame_bad()); end
    checks++; if (bus.core_ifft !== 1'b1)  begin errors++; $display("FAIL abort_start_ifft: got %b want 1", bus.core_ifft); end
  endtask

  task automatic test_abort_compute();
    int stray = 0;
    load_frame(1'b0, 1'b0);
    for (int i = 0; i < 51; i++) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++; if (bus.in_ready !== 1'b1)  begin errors++; $display("FAIL abort_cmp_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL abort_cmp_busy: got %b want 0", bus.busy); end
    checks++; if (frame_bad() != 0)       begin errors++; $display("FAIL abort_cmp_keep: got %0d bad words want 0", frame_bad()); end
    for (int i = 0; i < 250; i++) begin
      if (bus.out_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.core_start !== 1'b0) stray++;
      tick();
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL abort_cmp_stray: got %0d active cycles want 0", stray); end
  endtask

  task automatic test_back_to_back();
    int n; int acc; int cyc; int bad; int dones; bit ifft;
    for (int f = 0; f < 3; f++) begin
      ifft = 1'($urandom);
      set_stub(1'b0);
      load_frame(1'b0, ifft);
      checks++; if (bus.core_start !== 1'b1) begin errors++; $display("FAIL b2b_start[%0d]: got %b want 1", f, bus.core_start); end
      checks++; if (bus.core_ifft !== ifft)  begin errors++; $display("FAIL b2b_ifft[%0d]: got %b want %b", f, bus.core_ifft, ifft); end
      checks++; if (frame_bad() != 0)        begin errors++; $display("FAIL b2b_core_in[%0d]: got %0d bad words want 0", f, frame_bad()); end
      wait_valid(n);
      checks++; if (n != C + 1) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", f, n, C + 1); end
      acc = 0; cyc = 0; bad = 0; dones = 0;
      while (acc < D && cyc < 1000) begin
        bus.out_ready = ($urandom_range(3) != 0);
        if (bus.out_valid !== 1'b1 || bus.out_index !== L'(acc) ||
            bus.out_re !== stub_re[acc] || bus.out_im !== stub_im[acc] ||
            bus.out_last !== (acc == D - 1)) bad++;
        if (bus.out_ready) acc++;
        tick(); cyc++;
        if (bus.frame_done === 1'b1) dones++;
      end
      bus.out_ready = 1'b0;
      checks++; if (bad != 0)   begin errors++; $display("FAIL b2b_stream[%0d]: got %0d bad beats want 0", f, bad); end
      checks++; if (dones != 1 || bus.frame_done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %0d pulses want 1", f, dones); end
    end
  endtask

  task automatic test_reset_drain();
    int n;
    set_stub(1'b0);
    load_frame(1'b0, 1'b1);
    wait_valid(n);
    checks++; if (n != C + 1) begin errors++; $display("FAIL rd_latency: got %0d want %0d", n, C + 1); end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.out_ready = 1'b0;
    checks++; if (bus.out_index !== 6'd20) begin errors++; $display("FAIL rd_index: got %0d want 20", bus.out_index); end
    rst = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL rd_in_ready: got %b want 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL rd_out_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.out_last !== 1'b0)   begin errors++; $display("FAIL rd_out_last: got %b want 0", bus.out_last); end
    checks++; if (bus.out_index !== 6'd0)  begin errors++; $display("FAIL rd_out_index: got %0d want 0", bus.out_index); end
    checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL rd_busy: got %b want 0", bus.busy); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL rd_frame_done: got %b want 0", bus.frame_done); end
    checks++; if (bus.core_start !== 1'b0) begin errors++; $display("FAIL rd_core_start: got %b want 0", bus.core_start); end
    checks++; if (bus.core_ifft !== 1'b0)  begin errors++; $display("FAIL rd_core_ifft: got %b want 0", bus.core_ifft); end
    checks++; if (zero_bad() != 0)         begin errors++; $display("FAIL rd_core_in: got %0d nonzero words want 0", zero_bad()); end
    rst = 1'b1;
    tick();
  endtask

  initial begin
    set_stub(1'b1);
    test_reset();
    test_ramp_latency();
    test_backpressure();
    test_gaps_direction();
    test_abort_start();
    test_abort_compute();
    test_back_to_back();
    test_reset_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
